// File: rtl/lsu_pkg.sv
// Shared encodings and tag layout for the pipelined load/store unit.
// Tag fields are sized for the widest (64-bit) data path so one layout serves both widths.
package lsu_pkg;

  localparam logic [1:0] LSU_SZ_B = 2'b00;
  localparam logic [1:0] LSU_SZ_H = 2'b01;
  localparam logic [1:0] LSU_SZ_W = 2'b10;
  localparam logic [1:0] LSU_SZ_D = 2'b11;

  localparam int LSU_UNSIGNED_BIT = 2;
  localparam int LSU_OFFSET_W     = 3;

  typedef struct packed {
    logic [LSU_OFFSET_W-1:0] offset;
    logic [2:0]              opcode;
  } lsu_tag_t;

  localparam int LSU_TAG_W = $bits(lsu_tag_t);

  // A doubleword request on a 32-bit path is treated as a word.
  function automatic logic [1:0] lsu_eff_size(input logic [1:0] size, input int data_width);
    return (size == LSU_SZ_D && data_width == 32) ? LSU_SZ_W : size;
  endfunction

endpackage

// File: rtl/lsu_pipelined_if.sv
// Avalon-MM pipelined data bus between the LSU (master) and memory (slave).
interface lsu_pipelined_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  dbus_read;
  logic                  dbus_write;
  logic [DATA_WIDTH-1:0] dbus_address;
  logic [DATA_WIDTH-1:0] dbus_writedata;
  logic [NB-1:0]         dbus_byte_enable;
  logic                  dbus_waitrequest;
  logic [DATA_WIDTH-1:0] dbus_readdata;
  logic                  dbus_readdatavalid;

  modport master (
    output dbus_read, dbus_write, dbus_address, dbus_writedata, dbus_byte_enable,
    input  dbus_waitrequest, dbus_readdata, dbus_readdatavalid
  );

  modport slave (
    input  dbus_read, dbus_write, dbus_address, dbus_writedata, dbus_byte_enable,
    output dbus_waitrequest, dbus_readdata, dbus_readdatavalid
  );

endinterface

// File: rtl/lsu_tag_fifo.sv
// Synchronous tag FIFO tracking in-flight reads; head is registered storage, no fall-through.
module lsu_tag_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; an entry is only read after a push has written it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/lsu_pipelined.sv
// Pipelined LSU: issues Avalon-MM reads/writes, tracks up to MAX_OUTSTANDING reads in a
// tag FIFO, and aligns/extends responses using the tag popped on readdatavalid.
module lsu_pipelined
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsu_mem_read,
  input  logic                  lsu_mem_write,
  input  logic [2:0]            lsu_mem_opcode,
  input  logic [DATA_WIDTH-1:0] lsu_address,
  input  logic [DATA_WIDTH-1:0] lsu_writedata,
  output logic [DATA_WIDTH-1:0] lsu_readdata,
  output logic                  lsu_readdata_valid,
  output logic                  lsu_stall_req,
  output logic                  lsu_idle,
  output logic                  lsu_resp_error,
  output logic                  lsu_exception_load_addr_misaligned,
  output logic                  lsu_exception_store_addr_misaligned,
  lsu_pipelined_if.master       dbus
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic [1:0]            req_size;
  logic [3:0]            req_bytes;
  logic [OW-1:0]         req_off;
  logic                  misaligned;
  logic [NB-1:0]         be_mask;
  logic [DATA_WIDTH-1:0] wdata_rep;
  logic                  issue_read;
  logic                  issue_write;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_pop;
  lsu_tag_t              push_tag;
  lsu_tag_t              head_tag;
  logic [1:0]            rsp_size;
  logic [3:0]            rsp_bytes;
  logic [DATA_WIDTH-1:0] rsp_lane;
  logic                  rsp_sign;

  // ---------------- request decode ----------------
  assign req_size  = lsu_eff_size(lsu_mem_opcode[1:0], DATA_WIDTH);
  assign req_bytes = 4'd1 << req_size;
  assign req_off   = lsu_address[OW-1:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    misaligned = 1'b0;
    case (req_size)
      LSU_SZ_H: misaligned = lsu_address[0];
      LSU_SZ_W: misaligned = |lsu_address[1:0];
      LSU_SZ_D: misaligned = |lsu_address[2:0];
      default:  misaligned = 1'b0;
    endcase
  end

  // Lane mask and store-data replication; req_bytes is a power of two so '&' acts as modulo.
  always_comb begin
    be_mask   = '0;
    wdata_rep = '0;
    for (int i = 0; i < NB; i++) begin
      be_mask[i]          = (i < int'(req_bytes));
      wdata_rep[8*i +: 8] = lsu_writedata[8*(i & (int'(req_bytes) - 1)) +: 8];
    end
  end

  // ---------------- issue ----------------
  assign issue_read  = lsu_mem_read & ~misaligned & ~fifo_full;
  assign issue_write = lsu_mem_write & ~misaligned;

  assign dbus.dbus_read        = issue_read;
  assign dbus.dbus_write       = issue_write;
  assign dbus.dbus_address     = lsu_address & ~DATA_WIDTH'(NB - 1);
  assign dbus.dbus_writedata   = wdata_rep;
  assign dbus.dbus_byte_enable = be_mask << req_off;

  assign lsu_exception_load_addr_misaligned  = lsu_mem_read & misaligned;
  assign lsu_exception_store_addr_misaligned = lsu_mem_write & misaligned;

  // A pop in the same cycle does not free a slot for the blocked read.
  assign lsu_stall_req = ((issue_read | issue_write) & dbus.dbus_waitrequest)
                       | (lsu_mem_read & ~misaligned & fifo_full);

  // ---------------- tag tracking ----------------
  assign push_tag = '{offset: LSU_OFFSET_W'(req_off), opcode: lsu_mem_opcode};
  assign fifo_pop = dbus.dbus_readdatavalid & ~fifo_empty;

  lsu_tag_fifo #(
    .WIDTH (LSU_TAG_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (issue_read & ~dbus.dbus_waitrequest),
    .push_data (push_tag),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head_tag)
  );

  assign lsu_idle = (fifo_count == '0);

  // ---------------- response ----------------
  assign rsp_size  = lsu_eff_size(head_tag.opcode[1:0], DATA_WIDTH);
  assign rsp_bytes = 4'd1 << rsp_size;
  assign rsp_lane  = dbus.dbus_readdata >> {head_tag.offset, 3'b000};
  // Full-width results have no fill bytes, so the unsigned bit drops out naturally for them.
  assign rsp_sign  = ~head_tag.opcode[LSU_UNSIGNED_BIT] & rsp_lane[8*int'(rsp_bytes) - 1];

  always_comb begin
    lsu_readdata = '0;
    for (int i = 0; i < NB; i++) begin
      lsu_readdata[8*i +: 8] = (i < int'(rsp_bytes)) ? rsp_lane[8*i +: 8] : {8{rsp_sign}};
    end
  end

  assign lsu_readdata_valid = fifo_pop;

  always_ff @(posedge clk) begin
    if (!rst_n)                                         lsu_resp_error <= 1'b0;
    else if (dbus.dbus_readdatavalid && fifo_empty)     lsu_resp_error <= 1'b1;
  end

endmodule

// File: tb/tb_lsu_pipelined.sv
// Directed bench for lsu_pipelined: a 32-bit and a 64-bit instance, both with two outstanding reads.
module tb_lsu_pipelined;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // 32-bit instance
  logic        a_rd, a_wr;
  logic [2:0]  a_op;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        a_valid, a_stall, a_idle, a_err, a_lexc, a_sexc;
  lsu_pipelined_if #(.DATA_WIDTH(32)) a_bus ();

  lsu_pipelined #(.DATA_WIDTH(32), .MAX_OUTSTANDING(2)) u_a (
    .clk (clk), .rst_n (rst_n),
    .lsu_mem_read (a_rd), .lsu_mem_write (a_wr), .lsu_mem_opcode (a_op),
    .lsu_address (a_addr), .lsu_writedata (a_wdata),
    .lsu_readdata (a_rdata), .lsu_readdata_valid (a_valid),
    .lsu_stall_req (a_stall), .lsu_idle (a_idle), .lsu_resp_error (a_err),
    .lsu_exception_load_addr_misaligned (a_lexc),
    .lsu_exception_store_addr_misaligned (a_sexc),
    .dbus (a_bus)
  );

  // 64-bit instance
  logic        b_rd, b_wr;
  logic [2:0]  b_op;
  logic [63:0] b_addr, b_wdata, b_rdata;
  logic        b_valid, b_stall, b_idle, b_err, b_lexc, b_sexc;
  lsu_pipelined_if #(.DATA_WIDTH(64)) b_bus ();

  lsu_pipelined #(.DATA_WIDTH(64), .MAX_OUTSTANDING(2)) u_b (
    .clk (clk), .rst_n (rst_n),
    .lsu_mem_read (b_rd), .lsu_mem_write (b_wr), .lsu_mem_opcode (b_op),
    .lsu_address (b_addr), .lsu_writedata (b_wdata),
    .lsu_readdata (b_rdata), .lsu_readdata_valid (b_valid),
    .lsu_stall_req (b_stall), .lsu_idle (b_idle), .lsu_resp_error (b_err),
    .lsu_exception_load_addr_misaligned (b_lexc),
    .lsu_exception_store_addr_misaligned (b_sexc),
    .dbus (b_bus)
  );

  localparam logic [2:0] OP_LB = 3'b000, OP_LH = 3'b001, OP_LW = 3'b010, OP_LD = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100, OP_LWU = 3'b110;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, outputs are sampled 1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_rd = 0; a_wr = 0; a_op = '0; a_addr = '0; a_wdata = '0;
    b_rd = 0; b_wr = 0; b_op = '0; b_addr = '0; b_wdata = '0;
    a_bus.dbus_waitrequest = 0; a_bus.dbus_readdata = '0; a_bus.dbus_readdatavalid = 0;
    b_bus.dbus_waitrequest = 0; b_bus.dbus_readdata = '0; b_bus.dbus_readdatavalid = 0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("reset_idle_a", a_idle, 1);
    check("reset_valid_a", a_valid, 0);
    check("reset_err_a", a_err, 0);
    check("reset_idle_b", b_idle, 1);

    // SH addr 0x2 under 3 cycles of waitrequest
    a_wr = 1; a_op = OP_LH; a_addr = 32'h2; a_wdata = 32'h0000_1234;
    a_bus.dbus_waitrequest = 1;
    #1;
    check("sh_write", a_bus.dbus_write, 1);
    check("sh_wdata", a_bus.dbus_writedata, 32'h1234_1234);
    check("sh_be", a_bus.dbus_byte_enable, 4'b1100);
    check("sh_addr", a_bus.dbus_address, 32'h0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      check("sh_stall_wait", a_stall, 1);
    end
    tick();
    a_bus.dbus_waitrequest = 0;
    #1;
    check("sh_stall_released", a_stall, 0);
    check("sh_write_accept", a_bus.dbus_write, 1);
    // misaligned SW is not issued
    a_op = OP_LW; a_addr = 32'h2;
    #1;
    check("sw_mis_exc", a_sexc, 1);
    check("sw_mis_write", a_bus.dbus_write, 0);
    check("sw_mis_lexc", a_lexc, 0);
    a_wr = 0;
    tick();

    // LB addr 0x103
    a_rd = 1; a_op = OP_LB; a_addr = 32'h103;
    #1;
    check("lb_be", a_bus.dbus_byte_enable, 4'b1000);
    check("lb_addr", a_bus.dbus_address, 32'h100);
    check("lb_read", a_bus.dbus_read, 1);
    tick();
    a_rd = 0;
    #1;
    check("lb_busy", a_idle, 0);
    a_bus.dbus_readdatavalid = 1; a_bus.dbus_readdata = 32'h80FF_FF00;
    #1;
    check("lb_valid", a_valid, 1);
    check("lb_data", a_rdata, 32'hFFFF_FF80);
    tick();
    a_bus.dbus_readdatavalid = 0;
    #1;
    check("lb_idle_after", a_idle, 1);

    // Three back-to-back reads against two slots
    a_rd = 1; a_op = OP_LBU; a_addr = 32'h101;
    #1;
    check("r1_read", a_bus.dbus_read, 1);
    check("r1_stall", a_stall, 0);
    tick();
    a_op = OP_LH; a_addr = 32'h2;
    #1;
    check("r2_read", a_bus.dbus_read, 1);
    check("r2_stall", a_stall, 0);
    tick();
    a_op = OP_LW; a_addr = 32'h8;
    #1;
    check("r3_blocked_read", a_bus.dbus_read, 0);
    check("r3_blocked_stall", a_stall, 1);
    tick();
    a_bus.dbus_readdatavalid = 1; a_bus.dbus_readdata = 32'h0000_8000;
    #1;
    check("r3_stall_during_pop", a_stall, 1);
    check("r1_valid", a_valid, 1);
    check("r1_data", a_rdata, 32'h0000_0080);
    tick();
    a_bus.dbus_readdatavalid = 0;
    #1;
    check("r3_issue", a_bus.dbus_read, 1);
    check("r3_stall_clear", a_stall, 0);
    tick();
    a_rd = 0;
    a_bus.dbus_readdatavalid = 1; a_bus.dbus_readdata = 32'h8001_0000;
    #1;
    check("r2_valid", a_valid, 1);
    check("r2_data", a_rdata, 32'hFFFF_8001);
    tick();
    a_bus.dbus_readdata = 32'h7654_3210;
    #1;
    check("r3_valid", a_valid, 1);
    check("r3_data", a_rdata, 32'h7654_3210);
    tick();
    a_bus.dbus_readdatavalid = 0;
    #1;
    check("seq_idle", a_idle, 1);

    // Size 11 on a 32-bit path decodes as a word
    a_rd = 1; a_op = OP_LD; a_addr = 32'h4;
    #1;
    check("ld32_lexc", a_lexc, 0);
    check("ld32_be", a_bus.dbus_byte_enable, 4'b1111);
    check("ld32_read", a_bus.dbus_read, 1);
    a_rd = 0;
    tick();

    // 64-bit: LWU and LW at addr 0x4
    b_rd = 1; b_op = OP_LWU; b_addr = 64'h4;
    #1;
    check("lwu64_be", b_bus.dbus_byte_enable, 8'hF0);
    check("lwu64_read", b_bus.dbus_read, 1);
    tick();
    b_op = OP_LW;
    tick();
    b_rd = 0;
    b_bus.dbus_readdatavalid = 1; b_bus.dbus_readdata = 64'h8000_0001_DEAD_BEEF;
    #1;
    check("lwu64_valid", b_valid, 1);
    check("lwu64_data", b_rdata, 64'h0000_0000_8000_0001);
    tick();
    #1;
    check("lw64_data", b_rdata, 64'hFFFF_FFFF_8000_0001);
    tick();
    b_bus.dbus_readdatavalid = 0;
    b_rd = 1; b_op = OP_LD; b_addr = 64'h4;
    #1;
    check("ld64_mis_exc", b_lexc, 1);
    check("ld64_mis_read", b_bus.dbus_read, 0);
    check("ld64_mis_stall", b_stall, 0);
    b_rd = 0; b_wr = 1; b_op = OP_LH; b_addr = 64'h6; b_wdata = 64'hABCD;
    #1;
    check("sh64_wdata", b_bus.dbus_writedata, 64'hABCD_ABCD_ABCD_ABCD);
    check("sh64_be", b_bus.dbus_byte_enable, 8'hC0);
    b_wr = 0;
    tick();
    check("b_idle_end", b_idle, 1);

    // Stray readdatavalid while idle
    a_bus.dbus_readdatavalid = 1; a_bus.dbus_readdata = 32'hFFFF_FFFF;
    #1;
    check("stray_valid", a_valid, 0);
    tick();
    a_bus.dbus_readdatavalid = 0;
    #1;
    check("stray_err", a_err, 1);
    tick();
    check("stray_err_sticky", a_err, 1);
    check("stray_idle", a_idle, 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    check("err_cleared", a_err, 0);

    // Reset with two reads outstanding
    a_rd = 1; a_op = OP_LW; a_addr = 32'h0;
    tick();
    a_addr = 32'h4;
    tick();
    a_rd = 0;
    #1;
    check("two_out_busy", a_idle, 0);
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    check("rst_mid_idle", a_idle, 1);
    a_rd = 1;
    #1;
    check("rst_mid_not_full", a_stall, 0);
    a_rd = 0;
    a_bus.dbus_readdatavalid = 1;
    #1;
    check("late_valid", a_valid, 0);
    tick();
    a_bus.dbus_readdatavalid = 0;
    #1;
    check("late_err", a_err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_pipelined.md
# lsu_pipelined

Pipelined load/store unit: the parametrised successor of the single-outstanding LSU. It sits between the EX/MEM stages and the data bus. It issues Avalon-MM pipelined reads and writes, and keeps up to MAX_OUTSTANDING reads in flight, tracked by a tag FIFO. Responses return on readdatavalid and are aligned and sign/zero-extended for 32- or 64-bit data paths. It also flags misaligned accesses and exposes an idle indication for fences.

## Interface
- DATA_WIDTH, 32, data/address width; legal values 32 or 64.
- MAX_OUTSTANDING, 2, maximum in-flight reads; power of two, 1..16.
- Derived: NB = DATA_WIDTH/8 byte lanes; OW = log2(NB) offset bits.
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- lsu_mem_read / lsu_mem_write  in  1  EX-stage request; never both high.
- lsu_mem_opcode  in  3  [1:0] size: 00 B, 01 H, 10 W, 11 D; [2] unsigned.
- lsu_address  in  DATA_WIDTH  byte address.
- lsu_writedata  in  DATA_WIDTH  store data, LSB-aligned.
- dbus_read / dbus_write  out  1  Avalon command.
- dbus_address  out  DATA_WIDTH  lsu_address with low OW bits forced to 0.
- dbus_writedata  out  DATA_WIDTH  store data replicated across lanes.
- dbus_byte_enable  out  NB  lane enables.
- dbus_waitrequest  in  1  slave back-pressure.
- dbus_readdata  in  DATA_WIDTH  read data, not lane-aligned.
- dbus_readdatavalid  in  1  read response strobe.
- lsu_readdata  out  DATA_WIDTH  aligned, extended load result.
- lsu_readdata_valid  out  1  lsu_readdata is valid this cycle.
- lsu_stall_req  out  1  hold EX request.
- lsu_idle  out  1  no reads outstanding.
- lsu_resp_error  out  1  sticky: readdatavalid seen with no outstanding read.
- lsu_exception_load_addr_misaligned / lsu_exception_store_addr_misaligned  out  1  misaligned exceptions.

## Operation
- Size decode:
  - Size 11 is legal only when DATA_WIDTH=64; at 32 it decodes as W.
  - Unsigned bit is ignored for D, and for W when DATA_WIDTH=32.
- Misalignment:
  - H requires addr[0]=0; W requires addr[1:0]=0; D requires addr[2:0]=0.
  - Misaligned requests raise the matching exception combinationally and are never issued.
- Byte enables and write data:
  - byte_enable is the size mask (1/3/F/FF) shifted left by addr[OW-1:0].
  - writedata is the low size bytes replicated NB/size times.
- Tag FIFO:
  - Entries hold {addr[OW-1:0], opcode}, depth MAX_OUTSTANDING, with an occupancy counter.
  - Push on accepted read: dbus_read & ~dbus_waitrequest.
  - Pop on dbus_readdatavalid when not empty.
- Response:
  - lsu_readdata_valid = dbus_readdatavalid & ~empty.
  - lsu_readdata selects the lane from the popped head offset, then sign- or zero-extends per the popped opcode.
  - All response logic is combinational from the FIFO head.
- Issue gating:
  - dbus_read = lsu_mem_read & ~misaligned & ~full.
  - dbus_write = lsu_mem_write & ~misaligned. Stores never wait on outstanding reads; Avalon ordering holds.
- Stall:
  - lsu_stall_req = (dbus_read|dbus_write) & dbus_waitrequest, OR lsu_mem_read & ~misaligned & full.
  - Full blocks issue even when a pop occurs the same cycle; no same-cycle pop/push bypass at full.
- Error: readdatavalid while empty sets lsu_resp_error; no pop, no valid. The flag clears only on reset.
- lsu_idle = (count==0).

## Timing
- Reset (rst_n=0 at a clk edge):
  - Count, pointers and lsu_resp_error go to 0.
  - lsu_idle=1; lsu_readdata_valid=0.
  - All dbus outputs follow the inputs combinationally; none are registered.
- Read latency: ≥1 cycle, set by the slave; result appears in the readdatavalid cycle.
- Simultaneous push and pop when neither full nor empty: count unchanged.
- A push to an empty FIFO cannot pop the same cycle; readdatavalid in the push cycle is an error.
- Reset mid-operation: in-flight tags are discarded. A late readdatavalid after reset sets lsu_resp_error. The bus must be quiesced externally first.
- Pointers wrap modulo MAX_OUTSTANDING; count width is log2(MAX_OUTSTANDING)+1.

## Structure
- Package lsu_pkg holds:
  - Size encodings (LSU_SZ_B/H/W/D) and the unsigned bit index.
  - Tag struct lsu_tag_t {offset, opcode}, parametrised via a localparam width set for the 64-bit maximum.
- Sub-module lsu_tag_fifo:
  - Synchronous FIFO with params WIDTH and DEPTH.
  - Ports: push, pop, full, empty, count, head data; no fall-through.
  - Parent module holds decode, lane select and extension.

## Test plan
- DATA_WIDTH=32, LB addr 0x103, readdata 0x80FF_FF00 → lsu_readdata 0xFFFF_FF80; byte_enable 1000.
- DATA_WIDTH=64, LWU addr 0x4, readdata 0x8000_0001_xxxx_xxxx → 0x0000_0000_8000_0001; LD addr 0x4 → load misaligned exception, dbus_read=0.
- MAX_OUTSTANDING=2:
  - Three back-to-back reads, no waitrequest → third stalls until the first readdatavalid.
  - Results return in order, each with the correct offset and sign handling.
- SH addr 0x2, data 0x1234 → writedata 0x1234_1234, byte_enable 1100; with waitrequest high 3 cycles → stall for exactly 3 cycles.
- readdatavalid with lsu_idle=1 → lsu_resp_error=1, lsu_readdata_valid=0; holds until rst_n=0.
- Reset asserted with 2 reads outstanding → next cycle lsu_idle=1, count=0; a subsequent readdatavalid sets lsu_resp_error.
